icache_fetch: RTL and testbench

- Direct-mapped instruction cache between the IF stage and the RAM controller's instruction-read channel.
- Hits return an instruction 1 cycle after the request is sampled.
- A miss issues one 32-bit read on the RAM controller's inst channel, fills the line and forwards the word.
- The data channel and arbitration stay in the RAM controller; this block only drives inst_en/inst_addr.

---
 rtl/icache_fetch_pkg.sv | 22 ++
 rtl/icache_array.sv | 43 ++++
 rtl/icache_fetch.sv | 106 ++++++++++
 tb/tb_icache_fetch.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/icache_fetch_pkg.sv
// Shared types and address helpers for the direct-mapped instruction cache.
package icache_fetch_pkg;

  localparam int ICACHE_ADDR_W  = 17;
  localparam int ICACHE_INDEX_W = 7;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  // Results are right-aligned in 32 bits; callers narrow with a size cast.
  function automatic logic [31:0] idx_of(input logic [31:0] addr, input int index_w);
    return (addr >> 2) & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int addr_w,
                                         input int index_w);
    return (addr >> (index_w + 2)) & ((32'd1 << (addr_w - index_w - 2)) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, one synchronous write, clear-all on reset.
module icache_array
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [INDEX_W-1:0] widx,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [31:0]        wdata,
  input  logic [INDEX_W-1:0] ridx,
  output logic               rvalid,
  output logic [TAG_W-1:0]   rtag,
  output logic [31:0]        rdata
);

  localparam int NLINES = 1 << INDEX_W;

  logic [NLINES-1:0] valid;
  logic [TAG_W-1:0]  tag_mem  [NLINES];
  logic [31:0]       data_mem [NLINES];

  always_ff @(posedge clk) begin
    if (!rst)    valid       <= '0;
    else if (we) valid[widx] <= 1'b1;
  end

  // Tag/data need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[widx]  <= wtag;
      data_mem[widx] <= wdata;
    end
  end

  assign rvalid = valid[ridx];
  assign rtag   = tag_mem[ridx];
  assign rdata  = data_mem[ridx];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped I-cache between IF and the RAM controller instruction channel.
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int ADDR_W  = ICACHE_ADDR_W,
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int TAG_W   = ADDR_W - INDEX_W - 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rst_c,
  input  logic        rdy,
  input  logic        if_en_i,
  input  logic [31:0] if_addr_i,
  output logic        if_rdy_o,
  output logic [31:0] if_inst_o,
  output logic        mem_en_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rdy_i,
  input  logic [31:0] mem_inst_i
);

  state_t             state, state_n;
  logic               if_rdy_n, mem_en_n, fill;
  logic [31:0]        if_inst_n, mem_addr_n;
  logic [INDEX_W-1:0] ridx, widx;
  logic [TAG_W-1:0]   req_tag, wtag, rtag;
  logic               rvalid, hit;
  logic [31:0]        rdata;

  assign ridx    = INDEX_W'(idx_of(if_addr_i, INDEX_W));
  assign req_tag = TAG_W'(tag_of(if_addr_i, ADDR_W, INDEX_W));
  // Fill target comes from the latched miss address, not the live PC.
  assign widx    = INDEX_W'(idx_of(mem_addr_o, INDEX_W));
  assign wtag    = TAG_W'(tag_of(mem_addr_o, ADDR_W, INDEX_W));
  assign hit     = rvalid && (rtag == req_tag);

  icache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (fill && rdy && rst),
    .widx   (widx),
    .wtag   (wtag),
    .wdata  (mem_inst_i),
    .ridx   (ridx),
    .rvalid (rvalid),
    .rtag   (rtag),
    .rdata  (rdata)
  );

  always_comb begin
    state_n    = state;
    if_rdy_n   = 1'b0;
    if_inst_n  = if_inst_o;
    mem_en_n   = mem_en_o;
    mem_addr_n = mem_addr_o;
    fill       = 1'b0;
    if (rst_c) begin
      state_n  = IDLE;
      mem_en_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // if_rdy_o high forces a bubble so a held request is not served twice.
          if (if_en_i && !if_rdy_o) begin
            if (hit) begin
              if_rdy_n  = 1'b1;
              if_inst_n = rdata;
            end else begin
              mem_en_n   = 1'b1;
              mem_addr_n = {if_addr_i[31:2], 2'b00};
              state_n    = MISS;
            end
          end
        end
        MISS: begin
          if (mem_rdy_i) begin
            fill      = 1'b1;
            if_rdy_n  = 1'b1;
            if_inst_n = mem_inst_i;
            mem_en_n  = 1'b0;
            state_n   = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      if_rdy_o   <= 1'b0;
      if_inst_o  <= '0;
      mem_en_o   <= 1'b0;
      mem_addr_o <= '0;
    end else if (rdy) begin
      state      <= state_n;
      if_rdy_o   <= if_rdy_n;
      if_inst_o  <= if_inst_n;
      mem_en_o   <= mem_en_n;
      mem_addr_o <= mem_addr_n;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch; inputs driven and outputs sampled on negedge.
module tb_icache_fetch;

  logic        clk = 1'b0;
  logic        rst, rst_c, rdy;
  logic        if_en_i;
  logic [31:0] if_addr_i;
  logic        if_rdy_o;
  logic [31:0] if_inst_o;
  logic        mem_en_o;
  logic [31:0] mem_addr_o;
  logic        mem_rdy_i;
  logic [31:0] mem_inst_i;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  icache_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .rst_c      (rst_c),
    .rdy        (rdy),
    .if_en_i    (if_en_i),
    .if_addr_i  (if_addr_i),
    .if_rdy_o   (if_rdy_o),
    .if_inst_o  (if_inst_o),
    .mem_en_o   (mem_en_o),
    .mem_addr_o (mem_addr_o),
    .mem_rdy_i  (mem_rdy_i),
    .mem_inst_i (mem_inst_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Miss: request, see the RAM read, return word, see the single response.
  task automatic do_miss(input string tag, input logic [31:0] addr, input logic [31:0] word);
    if_en_i = 1'b1; if_addr_i = addr;
    tick();
    chk({tag, ".mem_en"}, 32'(mem_en_o), 32'd1);
    chk({tag, ".mem_addr"}, mem_addr_o, addr);
    chk({tag, ".no_early_rdy"}, 32'(if_rdy_o), 32'd0);
    mem_rdy_i = 1'b1; mem_inst_i = word;
    tick();
    chk({tag, ".rdy"}, 32'(if_rdy_o), 32'd1);
    chk({tag, ".inst"}, if_inst_o, word);
    chk({tag, ".mem_en_drop"}, 32'(mem_en_o), 32'd0);
    mem_rdy_i = 1'b0; mem_inst_i = '0; if_en_i = 1'b0;
    tick();
    chk({tag, ".one_pulse"}, 32'(if_rdy_o), 32'd0);
  endtask

  task automatic do_hit(input string tag, input logic [31:0] addr, input logic [31:0] word);
    if_en_i = 1'b1; if_addr_i = addr;
    tick();
    chk({tag, ".rdy"}, 32'(if_rdy_o), 32'd1);
    chk({tag, ".inst"}, if_inst_o, word);
    chk({tag, ".no_mem"}, 32'(mem_en_o), 32'd0);
    if_en_i = 1'b0;
    tick();
    chk({tag, ".one_pulse"}, 32'(if_rdy_o), 32'd0);
  endtask

  initial begin
    rst = 1'b0; rst_c = 1'b0; rdy = 1'b1;
    if_en_i = 1'b0; if_addr_i = '0; mem_rdy_i = 1'b0; mem_inst_i = '0;
    tick(); tick();
    chk("rst.if_rdy", 32'(if_rdy_o), 32'd0);
    chk("rst.if_inst", if_inst_o, 32'd0);
    chk("rst.mem_en", 32'(mem_en_o), 32'd0);
    chk("rst.mem_addr", mem_addr_o, 32'd0);
    rst = 1'b1;
    tick();

    do_miss("cold", 32'h0000_0000, 32'h0000_0013);
    do_hit("hit0", 32'h0000_0000, 32'h0000_0013);

    // Index 1 shared by 0x004 (tag 0) and 0x204 (tag 1).
    do_miss("evA", 32'h0000_0004, 32'h1111_1111);
    do_hit("evA_hit", 32'h0000_0004, 32'h1111_1111);
    do_miss("evB", 32'h0000_0204, 32'h2222_2222);
    do_miss("evA2", 32'h0000_0004, 32'h1111_1111);

    // Flush before the fill returns; then a stale mem_rdy_i in IDLE.
    if_en_i = 1'b1; if_addr_i = 32'h0000_0100;
    tick();
    chk("fl.mem_en", 32'(mem_en_o), 32'd1);
    rst_c = 1'b1; if_en_i = 1'b0;
    tick();
    chk("fl.mem_en_off", 32'(mem_en_o), 32'd0);
    chk("fl.no_rdy", 32'(if_rdy_o), 32'd0);
    rst_c = 1'b0; mem_rdy_i = 1'b1; mem_inst_i = 32'hDEAD_BEEF;
    tick();
    chk("fl.stale_ignored", 32'(if_rdy_o), 32'd0);
    chk("fl.stale_no_mem", 32'(mem_en_o), 32'd0);
    mem_rdy_i = 1'b0; mem_inst_i = '0;
    do_miss("fl.refetch", 32'h0000_0100, 32'h0000_ABCD);

    // Flush coinciding with mem_rdy_i: fill for 0x300 (index 64) is discarded.
    if_en_i = 1'b1; if_addr_i = 32'h0000_0300;
    tick();
    chk("fl2.mem_en", 32'(mem_en_o), 32'd1);
    rst_c = 1'b1; mem_rdy_i = 1'b1; mem_inst_i = 32'h3333_3333; if_en_i = 1'b0;
    tick();
    chk("fl2.no_rdy", 32'(if_rdy_o), 32'd0);
    chk("fl2.mem_en_off", 32'(mem_en_o), 32'd0);
    rst_c = 1'b0; mem_rdy_i = 1'b0; mem_inst_i = '0;
    tick();
    do_hit("fl2.keep0100", 32'h0000_0100, 32'h0000_ABCD);

    // rdy stall during MISS.
    if_en_i = 1'b1; if_addr_i = 32'h0000_0008;
    tick();
    chk("st.mem_en", 32'(mem_en_o), 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st.hold_en", 32'(mem_en_o), 32'd1);
      chk("st.hold_addr", mem_addr_o, 32'h0000_0008);
      chk("st.no_rdy", 32'(if_rdy_o), 32'd0);
    end
    rdy = 1'b1; mem_rdy_i = 1'b1; mem_inst_i = 32'h0BAD_F00D;
    tick();
    chk("st.rdy", 32'(if_rdy_o), 32'd1);
    chk("st.inst", if_inst_o, 32'h0BAD_F00D);
    mem_rdy_i = 1'b0; mem_inst_i = '0; if_en_i = 1'b0;
    tick();
    do_hit("st.hit", 32'h0000_0008, 32'h0BAD_F00D);

    // Held hit request: responses alternate with bubbles.
    if_en_i = 1'b1; if_addr_i = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("held.rdy", 32'(if_rdy_o), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk("held.inst", if_inst_o, 32'h0000_0013);
    end
    if_en_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
